// File: rtl/wb_pipe_mem_pkg.sv
// Shared Wishbone definitions: bus widths, word-index/lane helpers, latency range
// and the request kind carried down the ack pipeline.
package wb_pipe_mem_pkg;

  localparam int unsigned WbAdrW     = 32;
  localparam int unsigned WbDatW     = 32;
  localparam int unsigned WbSelW     = 4;
  localparam int unsigned WbLaneW    = 8;
  localparam int unsigned WbAdrLsb   = 2;   // byte offset bits dropped from adr
  localparam int unsigned LatencyMin = 1;
  localparam int unsigned LatencyMax = 3;

  typedef enum logic {
    ReqWrite = 1'b0,
    ReqRead  = 1'b1
  } wb_req_e;

  // Word index of a byte address; bits above the memory depth alias.
  function automatic logic [WbAdrW-1:0] wb_word_index(input logic [WbAdrW-1:0] adr,
                                                      input int unsigned aw);
    return (adr >> WbAdrLsb) & ((WbAdrW'(1) << aw) - WbAdrW'(1));
  endfunction

  function automatic bit latency_legal(input int unsigned lat);
    return (lat >= LatencyMin) && (lat <= LatencyMax);
  endfunction

endpackage

// File: rtl/if_wb.sv
// Pipelined Wishbone bus bundle with master and slave views.
interface if_wb;
  logic        cyc;
  logic        stb;
  logic [31:0] adr;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] dat_w;  // master write data
  logic [31:0] dat_r;  // slave read data
  logic        ack;
  logic        stall;

  modport slave (
    input  cyc, stb, adr, we, sel, dat_w,
    output ack, stall, dat_r
  );

  modport master (
    output cyc, stb, adr, we, sel, dat_w,
    input  ack, stall, dat_r
  );
endinterface

// File: rtl/syncram_be.sv
// Single-port word RAM with per-byte write enables and a registered read port.
// Contents are never reset.
module syncram_be
  import wb_pipe_mem_pkg::*;
#(
  parameter int unsigned AWIDTH    = 12,
  parameter string       INIT_FILE = ""
) (
  input  logic              clk_i,
  input  logic              i_en,
  input  logic              i_we,
  input  logic [AWIDTH-1:0] i_addr,
  input  logic [WbSelW-1:0] i_be,
  input  logic [WbDatW-1:0] i_wdat,
  output logic [WbDatW-1:0] o_rdat
);

  localparam int unsigned Depth = 2 ** AWIDTH;

  logic [WbDatW-1:0] r_mem [Depth];
  logic [WbDatW-1:0] r_rdat;

  // Byte-lane write; unselected lanes keep their old contents.
  always_ff @(posedge clk_i) begin
    if (i_en && i_we) begin
      for (int n = 0; n < int'(WbSelW); n++) begin
        if (i_be[n]) r_mem[i_addr][WbLaneW*n +: WbLaneW] <= i_wdat[WbLaneW*n +: WbLaneW];
      end
    end
  end

  // Registered read; holds its value until the next read.
  always_ff @(posedge clk_i) begin
    if (i_en && !i_we) r_rdat <= r_mem[i_addr];
  end

  assign o_rdat = r_rdat;

endmodule

// File: rtl/wb_pipe_mem.sv
// Pipelined Wishbone memory responder. Each accepted request travels down a
// LATENCY-deep {valid, kind, data} shift pipeline and is acked when it leaves.
module wb_pipe_mem
  import wb_pipe_mem_pkg::*;
#(
  parameter int unsigned AWIDTH    = 12,
  parameter int unsigned LATENCY   = 2,
  parameter string       INIT_FILE = ""
) (
  input logic  clk_i,
  input logic  rst_i,
  if_wb.slave  bus,
  input logic  hold_i
);

  if (!latency_legal(LATENCY)) begin : g_bad_latency
    $fatal(1, "wb_pipe_mem: LATENCY must be within 1..3");
  end

  logic              w_stall;
  logic              w_accept;
  logic              w_ack;
  logic [AWIDTH-1:0] w_idx;
  logic [WbDatW-1:0] w_ram_q;

  // Per-stage views; index LATENCY-1 is the stage being acked.
  logic              w_vld  [LATENCY];
  wb_req_e           w_kind [LATENCY];
  logic [WbDatW-1:0] w_dat  [LATENCY];

  assign w_stall  = rst_i | hold_i;
  assign w_accept = bus.cyc & bus.stb & ~w_stall;
  assign w_idx    = AWIDTH'(wb_word_index(bus.adr, AWIDTH));

  syncram_be #(
    .AWIDTH   (AWIDTH),
    .INIT_FILE(INIT_FILE)
  ) u_ram (
    .clk_i (clk_i),
    .i_en  (w_accept),
    .i_we  (bus.we),
    .i_addr(w_idx),
    .i_be  (bus.sel),
    .i_wdat(bus.dat_w),
    .o_rdat(w_ram_q)
  );

  for (genvar g = 0; g < LATENCY; g++) begin : g_stage
    if (g == 0) begin : g_head
      logic    r_vld;
      wb_req_e r_kind;

      // Capture the request kind on the accept edge; the RAM register holds its data.
      always_ff @(posedge clk_i) begin
        if (rst_i || !bus.cyc) r_vld <= 1'b0;
        else                   r_vld <= w_accept;
        r_kind <= bus.we ? ReqWrite : ReqRead;
      end

      assign w_vld[g]  = r_vld;
      assign w_kind[g] = r_kind;
      assign w_dat[g]  = w_ram_q;
    end else begin : g_tail
      logic              r_vld;
      wb_req_e           r_kind;
      logic [WbDatW-1:0] r_dat;

      // Shift one stage; a dropped cyc or reset abandons everything in flight.
      always_ff @(posedge clk_i) begin
        if (rst_i || !bus.cyc) r_vld <= 1'b0;
        else                   r_vld <= w_vld[g-1];
        r_kind <= w_kind[g-1];
        r_dat  <= w_dat[g-1];
      end

      assign w_vld[g]  = r_vld;
      assign w_kind[g] = r_kind;
      assign w_dat[g]  = r_dat;
    end
  end

  // cyc and reset also mask the ack in the same cycle they take effect.
  assign w_ack     = w_vld[LATENCY-1] & bus.cyc & ~rst_i;
  assign bus.ack   = w_ack;
  assign bus.stall = w_stall;
  assign bus.dat_r = (w_ack && (w_kind[LATENCY-1] == ReqRead)) ? w_dat[LATENCY-1] : '0;

endmodule

// File: tb/tb_wb_pipe_mem.sv
// Scoreboard bench: two responders (LATENCY 2 and 3) share one stimulus stream.
// The driver predicts each accepted request's response from a word-array model
// and queues it with its due cycle; a negedge monitor pops and compares.
module tb_wb_pipe_mem;

  logic        clk = 1'b0;
  logic        rst, hold, cyc, stb, we;
  logic [31:0] adr, dat;
  logic [3:0]  sel;

  int cyc_n = 0;
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int          due;
    bit          rd;
    logic [31:0] dat;
  } exp_t;

  exp_t        q2[$];
  exp_t        q3[$];
  logic [31:0] mem_m [4096];

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  if_wb bus2();
  if_wb bus3();

  assign bus2.cyc = cyc;  assign bus2.stb = stb;  assign bus2.adr = adr;
  assign bus2.we  = we;   assign bus2.sel = sel;  assign bus2.dat_w = dat;
  assign bus3.cyc = cyc;  assign bus3.stb = stb;  assign bus3.adr = adr;
  assign bus3.we  = we;   assign bus3.sel = sel;  assign bus3.dat_w = dat;

  wb_pipe_mem #(.AWIDTH(12), .LATENCY(2), .INIT_FILE("")) dut2 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus2),
    .hold_i(hold)
  );

  wb_pipe_mem #(.AWIDTH(12), .LATENCY(3), .INIT_FILE("")) dut3 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus3),
    .hold_i(hold)
  );

  task automatic cmp(input string name, input int lat, input logic [31:0] got,
                     input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s L=%0d cycle %0d: got %h want %h", name, lat, cyc_n, got, want);
    end
  endtask

  task automatic check_port(input int lat, input logic ack, input logic [31:0] dr,
                            input logic st);
    logic        e_ack;
    logic [31:0] e_dat;
    e_ack = 1'b0;
    e_dat = 32'h0;
    if (lat == 2) begin
      if (q2.size() > 0 && q2[0].due == cyc_n) begin
        e_ack = 1'b1;
        if (q2[0].rd) e_dat = q2[0].dat;
        void'(q2.pop_front());
      end
    end else begin
      if (q3.size() > 0 && q3[0].due == cyc_n) begin
        e_ack = 1'b1;
        if (q3[0].rd) e_dat = q3[0].dat;
        void'(q3.pop_front());
      end
    end
    cmp("ack",   lat, {31'b0, ack}, {31'b0, e_ack});
    cmp("dat_r", lat, dr, e_dat);
    cmp("stall", lat, {31'b0, st}, {31'b0, rst | hold});
  endtask

  always @(negedge clk) begin
    check_port(2, bus2.ack, bus2.dat_r, bus2.stall);
    check_port(3, bus3.ack, bus3.dat_r, bus3.stall);
  end

  // Drive one cycle of bus inputs and predict the responses it produces.
  task automatic step(input logic c, input logic s, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] se, input logic r,
                      input logic h);
    exp_t e;
    int   idx;
    @(posedge clk);
    #1;
    cyc = c; stb = s; we = w; adr = a; dat = d; sel = se; rst = r; hold = h;
    if (r || !c) begin
      q2.delete();
      q3.delete();
    end
    if (c && s && !r && !h) begin
      idx = int'(a[13:2]);
      if (w) begin
        for (int n = 0; n < 4; n++) begin
          if (se[n]) mem_m[idx][8*n +: 8] = d[8*n +: 8];
        end
        e.rd  = 1'b0;
        e.dat = 32'h0;
      end else begin
        e.rd  = 1'b1;
        e.dat = mem_m[idx];
      end
      e.due = cyc_n + 2;
      q2.push_back(e);
      e.due = cyc_n + 3;
      q3.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
  endtask

  task automatic rd(input logic [31:0] a, input logic h);
    step(1'b1, 1'b1, 1'b0, a, $urandom, 4'hF, 1'b0, h);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] se);
    step(1'b1, 1'b1, 1'b1, a, d, se, 1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0] word;
    logic [31:0] a;
    logic        c, s, w, r, h;
    rst = 1'b1; hold = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    adr = 32'h0; dat = 32'h0; sel = 4'h0;
    repeat (3) step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0);

    // Fill a 16-word window with known contents (first acceptance right after reset).
    for (int i = 0; i < 16; i++) begin
      case (i)
        0:       word = 32'h1111_1111;
        1:       word = 32'h2222_2222;
        2:       word = 32'h3333_3333;
        4:       word = 32'h0000_0000;
        default: word = $urandom;
      endcase
      wr(32'(i) << 2, word, 4'hF);
    end
    idle(3);

    // Back-to-back read burst.
    rd(32'h0, 1'b0); rd(32'h4, 1'b0); rd(32'h8, 1'b0);
    idle(4);

    // Partial byte-lane write, then read back.
    wr(32'h10, 32'hAABB_CCDD, 4'b0101);
    idle(2);
    rd(32'h10, 1'b0);
    idle(4);

    // Read immediately after a write to the same word.
    wr(32'h20, 32'hDEAD_BEEF, 4'hF);
    rd(32'h20, 1'b0);
    idle(4);

    // hold_i during continuous strobes, rising while requests are in flight.
    rd(32'h4, 1'b0); rd(32'h8, 1'b1); rd(32'h8, 1'b1); rd(32'h8, 1'b1); rd(32'h8, 1'b0);
    idle(4);

    // Master drops cyc with reads in flight, then starts over.
    rd(32'h0, 1'b0); rd(32'h4, 1'b0);
    step(1'b0, 1'b1, 1'b0, 32'h8, 32'h0, 4'hF, 1'b0, 1'b0);
    rd(32'h8, 1'b0);
    idle(4);

    // Reset pulse in the middle of a read burst; earlier writes must survive.
    wr(32'h30, 32'h1234_5678, 4'hF);
    rd(32'h0, 1'b0); rd(32'h4, 1'b0);
    step(1'b1, 1'b1, 1'b0, 32'h8, 32'h0, 4'hF, 1'b1, 1'b0);
    rd(32'hC, 1'b0);
    idle(4);
    rd(32'h30, 1'b0); rd(32'h10, 1'b0); rd(32'h20, 1'b0);
    idle(4);

    // Random traffic over the window with aliased upper/low address bits.
    repeat (1500) begin
      c = ($urandom_range(0, 9) != 0);
      s = ($urandom_range(0, 3) != 0);
      w = 1'($urandom_range(0, 1));
      r = ($urandom_range(0, 99) == 0);
      h = ($urandom_range(0, 7) == 0);
      a = ($urandom & 32'hFFFF_C003) | (32'($urandom_range(0, 15)) << 2);
      step(c, s, w, a, $urandom, 4'($urandom_range(0, 15)), r, h);
    end

    // Halted master: pipeline drains.
    idle(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
